// File: rtl/normmult_pipe.sv
// Per-channel pedestal subtract and gain multiply, then scale, clamp and count saturations; 3-clock latency, 1 sample/clk, no stall.
// NORMMULT_ROUND_EN selects round-half-up before the scaling shift; default is floor (plain arithmetic shift).
module normmult_pipe #(
    parameter int DW    = 16,
    parameter int CW    = 16,
    parameter int CFRAC = 15,
    parameter int NCH   = 16,
    parameter int CHW   = $clog2(NCH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic signed [DW-1:0]  din,
    input  logic [CHW-1:0]        din_chan,
    input  logic                  din_valid,
    input  logic                  cwr,
    input  logic [CHW-1:0]        cwr_addr,
    input  logic [CW-1:0]         cwr_coef,
    input  logic signed [DW-1:0]  cwr_ped,
    output logic signed [DW-1:0]  dout,
    output logic [CHW-1:0]        dout_chan,
    output logic                  dout_valid,
    output logic                  dout_sat,
    output logic [15:0]           sat_cnt,
    input  logic                  sat_clr
);

    localparam int PW = DW + CW + 2;

`ifdef NORMMULT_ROUND_EN
    localparam logic signed [PW-1:0] RND = {{(PW-1){1'b0}}, 1'b1} << (CFRAC - 1);
`else
    localparam logic signed [PW-1:0] RND = '0;
`endif

    logic [CW-1:0]        r_coef [NCH];
    logic signed [DW-1:0] r_ped  [NCH];

    logic                 r_s1_vld;
    logic [CHW-1:0]       r_s1_chan;
    logic signed [DW:0]   r_s1_diff;
    logic [CW-1:0]        r_s1_coef;

    logic                 r_s2_vld;
    logic [CHW-1:0]       r_s2_chan;
    logic signed [PW-1:0] r_s2_prod;

    logic signed [DW-1:0] r_dout;
    logic [CHW-1:0]       r_dout_chan;
    logic                 r_dout_vld;
    logic                 r_dout_sat;
    logic [15:0]          r_sat_cnt;

    logic signed [DW:0]   w_diff;
    logic signed [DW-1:0] w_ped_rd;
    logic signed [PW-1:0] w_diff_x;
    logic signed [PW-1:0] w_coef_x;
    logic signed [PW-1:0] w_prod;
    logic signed [PW-1:0] w_sum;
    logic signed [PW-1:0] w_scaled;
    logic [PW-DW:0]       w_top;
    logic                 w_ovf;
    logic signed [DW-1:0] w_clamped;

    // Table writes land on the same edge that samples the read, so a colliding sample sees old values.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NCH; i++) begin
                r_coef[i] <= CW'(1) << CFRAC;
                r_ped[i]  <= '0;
            end
        end else if (cwr) begin
            r_coef[cwr_addr] <= cwr_coef;
            r_ped[cwr_addr]  <= cwr_ped;
        end
    end

    assign w_ped_rd = r_ped[din_chan];
    assign w_diff   = {din[DW-1], din} - {w_ped_rd[DW-1], w_ped_rd};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1_vld  <= 1'b0;
            r_s1_chan <= '0;
            r_s1_diff <= '0;
            r_s1_coef <= '0;
        end else begin
            r_s1_vld <= din_valid;
            if (din_valid) begin
                r_s1_chan <= din_chan;
                r_s1_diff <= w_diff;
                r_s1_coef <= r_coef[din_chan];
            end
        end
    end

    assign w_diff_x = {{(CW+1){r_s1_diff[DW]}}, r_s1_diff};
    assign w_coef_x = {{(DW+2){1'b0}}, r_s1_coef};
    assign w_prod   = w_diff_x * w_coef_x;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_s2_vld  <= 1'b0;
            r_s2_chan <= '0;
            r_s2_prod <= '0;
        end else begin
            r_s2_vld <= r_s1_vld;
            if (r_s1_vld) begin
                r_s2_chan <= r_s1_chan;
                r_s2_prod <= w_prod;
            end
        end
    end

    // The scaled value fits DW bits exactly when all bits from DW-1 upward match the sign.
    assign w_sum     = r_s2_prod + RND;
    assign w_scaled  = w_sum >>> CFRAC;
    assign w_top     = w_scaled[PW-1:DW-1];
    assign w_ovf     = !((&w_top) || !(|w_top));
    assign w_clamped = !w_ovf ? w_scaled[DW-1:0]
                     : (w_scaled[PW-1] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}});

    always_ff @(posedge clk) begin
        if (reset) begin
            r_dout_vld  <= 1'b0;
            r_dout      <= '0;
            r_dout_chan <= '0;
            r_dout_sat  <= 1'b0;
        end else begin
            r_dout_vld <= r_s2_vld;
            if (r_s2_vld) begin
                r_dout      <= w_clamped;
                r_dout_chan <= r_s2_chan;
                r_dout_sat  <= w_ovf;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset || sat_clr) begin
            r_sat_cnt <= '0;
        end else if (r_dout_vld && r_dout_sat && r_sat_cnt != 16'hFFFF) begin
            r_sat_cnt <= r_sat_cnt + 16'd1;
        end
    end

    assign dout       = r_dout;
    assign dout_chan  = r_dout_chan;
    assign dout_valid = r_dout_vld;
    assign dout_sat   = r_dout_sat;
    assign sat_cnt    = r_sat_cnt;

endmodule

// File: tb/tb_normmult_pipe.sv
// Directed bench for normmult_pipe with hand-computed expectations for both rounding builds.
// Inputs change on the falling edge; outputs are read on the falling edge.
module tb_normmult_pipe;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] din;
    logic [3:0]  din_chan;
    logic        din_valid;
    logic        cwr;
    logic [3:0]  cwr_addr;
    logic [15:0] cwr_coef;
    logic [15:0] cwr_ped;
    logic [15:0] dout;
    logic [3:0]  dout_chan;
    logic        dout_valid;
    logic        dout_sat;
    logic [15:0] sat_cnt;
    logic        sat_clr;

    int n_checks = 0;
    int n_errors = 0;

    normmult_pipe dut (
        .clk        (clk),
        .reset      (reset),
        .din        (din),
        .din_chan   (din_chan),
        .din_valid  (din_valid),
        .cwr        (cwr),
        .cwr_addr   (cwr_addr),
        .cwr_coef   (cwr_coef),
        .cwr_ped    (cwr_ped),
        .dout       (dout),
        .dout_chan  (dout_chan),
        .dout_valid (dout_valid),
        .dout_sat   (dout_sat),
        .sat_cnt    (sat_cnt),
        .sat_clr    (sat_clr)
    );

    always #4 clk = ~clk;

`ifdef NORMMULT_ROUND_EN
    localparam logic [15:0] EXP_P3 = 16'h0002;
    localparam logic [15:0] EXP_M3 = 16'hFFFF;
`else
    localparam logic [15:0] EXP_P3 = 16'h0001;
    localparam logic [15:0] EXP_M3 = 16'hFFFE;
`endif

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wr_tab(input logic [3:0] ch, input logic [15:0] coef, input logic [15:0] ped);
        @(negedge clk);
        cwr = 1'b1; cwr_addr = ch; cwr_coef = coef; cwr_ped = ped;
        @(negedge clk);
        cwr = 1'b0;
    endtask

    // One isolated sample: checks latency, result, and that outputs hold once valid drops.
    task automatic run_one(input string tag, input logic [3:0] ch, input logic [15:0] d,
                           input logic [15:0] exp, input logic exp_sat);
        int lat;
        @(negedge clk);
        din = d; din_chan = ch; din_valid = 1'b1;
        @(negedge clk);
        din_valid = 1'b0;
        lat = 1;
        while (!dout_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_lat"}, lat, 3);
        check({tag, "_dout"}, dout, exp);
        check({tag, "_chan"}, dout_chan, ch);
        check({tag, "_sat"}, dout_sat, exp_sat);
        @(negedge clk);
        check({tag, "_hold"}, {dout_valid, dout}, {1'b0, exp});
    endtask

    logic [3:0]  bb_ch  [4] = '{4'd5, 4'd6, 4'd5, 4'd6};
    logic [15:0] bb_din [4] = '{16'd1000, 16'd1000, 16'hF830, 16'd400};
    logic [15:0] bb_exp [4] = '{16'd500, 16'd750, 16'hFC18, 16'd300};

    initial begin
        reset = 1'b1; din = '0; din_chan = '0; din_valid = 1'b0;
        cwr = 1'b0; cwr_addr = '0; cwr_coef = '0; cwr_ped = '0; sat_clr = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("rst_state", {dout_valid, dout_sat, dout_chan, dout, sat_cnt}, '0);

        run_one("ch0_unity", 4'd0, 16'h1234, 16'h1234, 1'b0);

        wr_tab(4'd1, 16'h4000, 16'h0000);
        run_one("ch1_half", 4'd1, 16'hFF9C, 16'hFFCE, 1'b0);

        wr_tab(4'd2, 16'h4000, 16'h0000);
        run_one("ch2_p3", 4'd2, 16'h0003, EXP_P3, 1'b0);
        run_one("ch2_m3", 4'd2, 16'hFFFD, EXP_M3, 1'b0);

        wr_tab(4'd3, 16'hFFFF, 16'h0000);
        run_one("ch3_pos", 4'd3, 16'h7000, 16'h7FFF, 1'b1);
        check("satcnt1", sat_cnt, 16'd1);
        run_one("ch3_neg", 4'd3, 16'h8000, 16'h8000, 1'b1);
        check("satcnt2", sat_cnt, 16'd2);
        @(negedge clk); sat_clr = 1'b1;
        @(negedge clk); sat_clr = 1'b0;
        check("satclr", sat_cnt, 16'd0);

        wr_tab(4'd4, 16'h8000, 16'd100);
        run_one("ch4_ped", 4'd4, 16'd100, 16'd0, 1'b0);

        // Write and sample on the same edge, then a sample on the very next edge.
        @(negedge clk);
        cwr = 1'b1; cwr_addr = 4'd4; cwr_coef = 16'h8000; cwr_ped = 16'd50;
        din = 16'd100; din_chan = 4'd4; din_valid = 1'b1;
        @(negedge clk);
        cwr = 1'b0;
        @(negedge clk);
        din_valid = 1'b0;
        @(negedge clk);
        check("coll_old", {dout_valid, dout}, {1'b1, 16'd0});
        @(negedge clk);
        check("coll_new", {dout_valid, dout}, {1'b1, 16'd50});

        wr_tab(4'd5, 16'h4000, 16'h0000);
        wr_tab(4'd6, 16'h6000, 16'h0000);
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            if (i >= 3) begin
                check($sformatf("b2b%0d_dat", i - 3), {dout_valid, dout}, {1'b1, bb_exp[i-3]});
                check($sformatf("b2b%0d_chan", i - 3), dout_chan, bb_ch[i-3]);
            end
            if (i < 4) begin
                din = bb_din[i]; din_chan = bb_ch[i]; din_valid = 1'b1;
            end else begin
                din_valid = 1'b0;
            end
        end

        // Two samples in flight when reset hits: neither may emerge.
        @(negedge clk);
        din = 16'd1000; din_chan = 4'd5; din_valid = 1'b1;
        @(negedge clk);
        din = 16'd1000; din_chan = 4'd6;
        @(negedge clk);
        din_valid = 1'b0; reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("rst_flush%0d", i), {dout_valid, dout, sat_cnt}, '0);
            @(negedge clk);
        end
        run_one("rst_coef", 4'd3, 16'h1234, 16'h1234, 1'b0);
        run_one("rst_ped", 4'd4, 16'd100, 16'd100, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
